alarm_controller: RTL
=====================

# alarm_controller

Top-level sequencer for the alarm clock. It owns the user mode state machine and routes button edges either to the watch time-edit inputs or to its own BCD alarm register. It compares the alarm against the watch's current time and drives the ring/buzzer outputs, including ring timeout and optional snooze. It sits between the debounced button edge detectors, the `watch` block and the display driver.

## Interface
- `RING_SECS`, default 60: seconds of ringing before automatic stop.
- `SNOOZE_SECS`, default 300: snooze duration in seconds. Used only with `ALARM_SNOOZE_EN`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `sec_tick` in 1: one-cycle pulse, once per second.
- `mode_btn` in 1: one-cycle edge pulse; cycles the mode.
- `edit_btns` in 2: one-cycle edge pulses; hours (msb), minutes (lsb).
- `stop_btn` in 1: one-cycle edge pulse; silences the alarm.
- `alarm_en` in 1: level switch that arms the alarm.
- `current_time` in 20: watch time, 24 h BCD. Bits [19:18] hour tens, [17:14] hour units, [13:11] minute tens, [10:7] minute units, [6:4] second tens, [3:0] second units.
- `watch_edit_btns` out 2: registered edit pulses to the watch.
- `alarm_time` out 20: alarm register, same BCD layout. Seconds are always 0.
- `display_time` out 20: `alarm_time` in SET_ALARM, otherwise `current_time`.
- `mode` out 2: 0 = NORMAL, 1 = SET_TIME, 2 = SET_ALARM, 3 = ALERT (RINGING or SNOOZE).
- `ringing` out 1: high in RINGING.
- `buzzer` out 1: beep drive.

## Operation
- States: NORMAL, SET_TIME, SET_ALARM, RINGING, SNOOZE.
- Mode cycle on `mode_btn`: NORMAL -> SET_TIME -> SET_ALARM -> NORMAL.
- SET_TIME: `edit_btns` forwarded to `watch_edit_btns`.
- SET_ALARM: `edit_btns[1]` increments alarm hours, wrapping 23 -> 00 and x9 -> (x+1)0. `edit_btns[0]` increments alarm minutes, wrapping 59 -> 00 with no hour carry.
- All other states: `watch_edit_btns` = 0, alarm register unchanged.
- Match: `alarm_en` is high and `current_time[19:7] == alarm_time[19:7]` and `current_time[6:0] == 0`. The match flag is registered. Only its 0 -> 1 transition while in NORMAL fires NORMAL -> RINGING.
  - A match arising in SET_TIME or SET_ALARM is ignored.
  - Stopping within the same second does not re-fire.
- RINGING:
  - `ring_cnt` starts at 0 on entry and increments on each `sec_tick`.
  - Exits to NORMAL on `stop_btn`, on `mode_btn`, on `alarm_en` low, or when `ring_cnt == RING_SECS-1` coincides with `sec_tick`.
  - `buzzer` toggles on each `sec_tick`; it is forced to 0 outside RINGING.
- Priority within one cycle: `stop_btn` / `alarm_en` low > `mode_btn` > `edit_btns` > timeout > `sec_tick` counting.
- Counter width: $clog2 of max(`RING_SECS`, `SNOOZE_SECS`). The counter saturates and never wraps.

## Timing
- Reset (`reset` = 0 at a posedge):
  - State returns to NORMAL.
  - `alarm_time` = 20'h0 (00:00:00).
  - `watch_edit_btns`, `ringing` and `buzzer` = 0.
  - Counters clear; the match flag register clears.
- Reset mid-ring silences on the same edge.
- `watch_edit_btns`: one cycle latency from `edit_btns`.
- `alarm_time` updates on the clock edge after the button pulse.
- State transitions take effect one edge after the cause.
- `ringing`, `mode` and `buzzer` are registered and valid the cycle after the transition.
- `display_time` is combinational from the registered state and registered `alarm_time`.
- Match-to-RINGING: 2 cycles (match register, then state register).

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - In RINGING, any `edit_btns` pulse -> SNOOZE.
  - SNOOZE clears the counter and counts `SNOOZE_SECS` ticks, then returns to RINGING with a fresh `ring_cnt`.
  - `stop_btn`, `mode_btn` or `alarm_en` low in SNOOZE -> NORMAL.
  - `mode` = 3 in SNOOZE, with `ringing` = 0.
- Not defined: SNOOZE state absent and `edit_btns` ignored in RINGING.

## Structure
- Shared package `alarm_pkg`:
  - state enum `alarm_state_t`;
  - BCD field position localparams (HR_T, HR_U, MIN_T, MIN_U, SEC_T, SEC_U bit ranges);
  - constants `HOUR_MAX_BCD = 6'h23` and `MIN_MAX_BCD = 7'h59`.
- One sub-module: `bcd_hm_inc`, a combinational BCD hour/minute wrap incrementer (select hour or minute field). Used for the alarm register.

## Test plan
- Reset; mode pulse ×2; `edit_btns[1]` ×7, `edit_btns[0]` ×12 -> `alarm_time` = 07:12:00 and `display_time` = `alarm_time`. Mode pulse -> `mode` = 0.
- Alarm 23:59, `edit_btns[1]` once -> 00:59. `edit_btns[0]` once -> 00:00, with the hour not incremented.
- SET_TIME, `edit_btns` = 2'b10 -> `watch_edit_btns` = 2'b10 exactly one cycle later. In NORMAL the same stimulus -> 2'b00.
- Alarm 07:12, `alarm_en` = 1, `current_time` steps to 07:12:00 -> `ringing` = 1 two cycles later. `buzzer` toggles per tick; `ringing` = 0 after 60 ticks.
- Ringing then `stop_btn` -> NORMAL next edge. The match held for the rest of the second does not re-trigger. `alarm_en` = 0 at 07:12:00 -> no ring.
- With `ALARM_SNOOZE_EN`: ring, `edit_btns[0]` -> `mode` = 3, `ringing` = 0. After 300 ticks `ringing` = 1. `reset` low while snoozing -> NORMAL, all outputs at reset values.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock sequencer.
// Times are 24 h BCD: hh(6) mm(7) ss(7) packed into 20 bits.
package alarm_pkg;

  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    RINGING   = 3'd3,
    SNOOZE    = 3'd4
  } alarm_state_t;

  localparam int HR_T_HI  = 19, HR_T_LO  = 18;
  localparam int HR_U_HI  = 17, HR_U_LO  = 14;
  localparam int MIN_T_HI = 13, MIN_T_LO = 11;
  localparam int MIN_U_HI = 10, MIN_U_LO = 7;
  localparam int SEC_T_HI = 6,  SEC_T_LO = 4;
  localparam int SEC_U_HI = 3,  SEC_U_LO = 0;

  localparam logic [5:0] HOUR_MAX_BCD = 6'h23;
  localparam logic [6:0] MIN_MAX_BCD  = 7'h59;

  // RINGING and SNOOZE both report as ALERT.
  function automatic logic [1:0] mode_code(input alarm_state_t s);
    case (s)
      NORMAL:    return 2'd0;
      SET_TIME:  return 2'd1;
      SET_ALARM: return 2'd2;
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Button/time bundle between the alarm sequencer and its neighbours.
// master drives the button edges and watch time; slave is the controller.
interface alarm_controller_if;
  logic        sec_tick;
  logic        mode_btn;
  logic [1:0]  edit_btns;
  logic        stop_btn;
  logic        alarm_en;
  logic [19:0] current_time;
  logic [1:0]  watch_edit_btns;
  logic [19:0] alarm_time;
  logic [19:0] display_time;
  logic [1:0]  mode;
  logic        ringing;
  logic        buzzer;

  modport master (
    output sec_tick, mode_btn, edit_btns, stop_btn, alarm_en, current_time,
    input  watch_edit_btns, alarm_time, display_time, mode, ringing, buzzer
  );

  modport slave (
    input  sec_tick, mode_btn, edit_btns, stop_btn, alarm_en, current_time,
    output watch_edit_btns, alarm_time, display_time, mode, ringing, buzzer
  );
endinterface

// File: rtl/bcd_hm_inc.sv
// Combinational BCD hour or minute incrementer with wrap (23->00, 59->00).
// Minutes never carry into hours; seconds pass through untouched.
module bcd_hm_inc
  import alarm_pkg::*;
(
  input  logic [19:0] i_time,
  input  logic        i_sel_hour,
  output logic [19:0] o_time
);

  always_comb begin
    o_time = i_time;
    if (i_sel_hour) begin
      if (i_time[HR_T_HI:HR_U_LO] == HOUR_MAX_BCD) begin
        o_time[HR_T_HI:HR_U_LO] = '0;
      end else if (i_time[HR_U_HI:HR_U_LO] == 4'd9) begin
        o_time[HR_T_HI:HR_T_LO] = i_time[HR_T_HI:HR_T_LO] + 2'd1;
        o_time[HR_U_HI:HR_U_LO] = '0;
      end else begin
        o_time[HR_U_HI:HR_U_LO] = i_time[HR_U_HI:HR_U_LO] + 4'd1;
      end
    end else begin
      if (i_time[MIN_T_HI:MIN_U_LO] == MIN_MAX_BCD) begin
        o_time[MIN_T_HI:MIN_U_LO] = '0;
      end else if (i_time[MIN_U_HI:MIN_U_LO] == 4'd9) begin
        o_time[MIN_T_HI:MIN_T_LO] = i_time[MIN_T_HI:MIN_T_LO] + 3'd1;
        o_time[MIN_U_HI:MIN_U_LO] = '0;
      end else begin
        o_time[MIN_U_HI:MIN_U_LO] = i_time[MIN_U_HI:MIN_U_LO] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock sequencer: mode FSM, alarm register, match detect, ring/buzzer.
// Optional snooze is built when ALARM_SNOOZE_EN is defined.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic               clk,
  input  logic               reset,
  alarm_controller_if.slave  bus
);

  localparam int CNT_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW       = (CNT_SECS > 2) ? $clog2(CNT_SECS) : 1;
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);
  localparam logic [CW-1:0] CNT_SAT     = '1;

  alarm_state_t  r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic          r_match, r_match_d, w_match, w_silence, w_fire;
  logic [19:0]   r_alarm, w_alarm_inc;
  logic          w_alarm_edit;
  logic [1:0]    r_web;
  logic          r_ringing, r_buzzer;
  logic [1:0]    r_mode;

  bcd_hm_inc u_inc (
    .i_time     (r_alarm),
    .i_sel_hour (bus.edit_btns[1]),
    .o_time     (w_alarm_inc)
  );

  assign w_match = bus.alarm_en
                && (bus.current_time[HR_T_HI:MIN_U_LO] == r_alarm[HR_T_HI:MIN_U_LO])
                && (bus.current_time[SEC_T_HI:SEC_U_LO] == '0);
  // Fire only on the rising edge so a match held for the rest of the second is inert.
  assign w_fire       = r_match && !r_match_d;
  assign w_silence    = bus.stop_btn || !bus.alarm_en;
  assign w_cnt_inc    = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
  assign w_alarm_edit = (r_state == SET_ALARM) && !bus.mode_btn && (|bus.edit_btns);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      NORMAL: begin
        w_cnt_next = '0;
        if (bus.mode_btn)               w_next = SET_TIME;
        else if (w_fire && !w_silence)  w_next = RINGING;
      end
      SET_TIME: begin
        w_cnt_next = '0;
        if (bus.mode_btn) w_next = SET_ALARM;
      end
      SET_ALARM: begin
        w_cnt_next = '0;
        if (bus.mode_btn) w_next = NORMAL;
      end
      RINGING: begin
        if (w_silence || bus.mode_btn) begin
          w_next     = NORMAL;
          w_cnt_next = '0;
`ifdef ALARM_SNOOZE_EN
        end else if (|bus.edit_btns) begin
          w_next     = SNOOZE;
          w_cnt_next = '0;
`endif
        end else if (bus.sec_tick) begin
          if (r_cnt == RING_LAST) begin
            w_next     = NORMAL;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (w_silence || bus.mode_btn) begin
          w_next     = NORMAL;
          w_cnt_next = '0;
        end else if (bus.sec_tick) begin
          if (r_cnt == SNOOZE_LAST) begin
            w_next     = RINGING;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end
`endif
      default: begin
        w_next     = NORMAL;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= NORMAL;
      r_cnt     <= '0;
      r_match   <= 1'b0;
      r_match_d <= 1'b0;
      r_alarm   <= '0;
      r_web     <= 2'b00;
      r_ringing <= 1'b0;
      r_buzzer  <= 1'b0;
      r_mode    <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_match   <= w_match;
      r_match_d <= r_match;
      if (w_alarm_edit) r_alarm <= w_alarm_inc;
      r_web     <= (r_state == SET_TIME && !bus.mode_btn) ? bus.edit_btns : 2'b00;
      r_ringing <= (w_next == RINGING);
      r_mode    <= mode_code(w_next);
      // Toggle only while staying in RINGING; entering or leaving holds/forces low.
      if (w_next != RINGING)                      r_buzzer <= 1'b0;
      else if (r_state == RINGING && bus.sec_tick) r_buzzer <= ~r_buzzer;
    end
  end

  assign bus.watch_edit_btns = r_web;
  assign bus.alarm_time      = r_alarm;
  assign bus.display_time    = (r_state == SET_ALARM) ? r_alarm : bus.current_time;
  assign bus.mode            = r_mode;
  assign bus.ringing         = r_ringing;
  assign bus.buzzer          = r_buzzer;

endmodule
